// File: rtl/int_to_fp_arbiter.sv
// Round-robin front end that time-shares one external combinational int_to_fp
// converter; holds the granted operand for CONV_LAT cycles and returns a tagged result.
//
// state | meaning
// IDLE  | waiting for any req_valid; grants one requester combinationally
// WAIT  | operand held on conv_int while the converter settles (cnt counts down)
// OUT   | result presented on res_*; held until res_ready
module int_to_fp_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int CONV_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_int,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            conv_int,
  input  logic [31:0]            conv_fp,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_fp,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy,
  output logic [15:0]            done_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  logic            grant_any;
  logic [3:0]      cnt;
  logic [15:0]     done_q;
  logic            accept;
  logic            settle;
  logic            counting;
  logic            complete;
  logic [31:0]     ops [NUM_REQ];

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ops
    assign ops[gi] = req_int[32*gi +: 32];
  end

  // Search from the largest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = wrap_idx(rr_ptr, k);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    settle    = 1'b0;
    counting  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          settle    = 1'b1;
          state_nxt = OUT;
        end else begin
          counting  = 1'b1;
        end
      end
      OUT: begin
        if (res_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      cnt       <= '0;
      conv_int  <= '0;
      res_fp    <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      done_q    <= '0;
    end else begin
      if (accept) begin
        conv_int <= ops[grant_id];
        id_q     <= grant_id;
        cnt      <= 4'(CONV_LAT);
        rr_ptr   <= wrap_idx(grant_id, 1);
      end
      if (counting) cnt <= cnt - 4'd1;
      if (settle) begin
        res_fp    <= conv_fp;
        res_id    <= id_q;
        res_valid <= 1'b1;
      end
      if (complete) begin
        res_valid <= 1'b0;
        done_q    <= done_q + 16'd1;
      end
    end
  end

  assign req_ready = (state == IDLE && grant_any) ?
                     ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
  assign busy      = (state != IDLE);
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_int_to_fp_arbiter.sv
// Directed bench for int_to_fp_arbiter: a behavioural int_to_fp model closes the
// conv_int -> conv_fp loop; a second instance covers a longer settle time.
module tb_int_to_fp_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_int;
  logic [31:0]  conv_int, conv_fp, res_fp;
  logic         res_valid, res_ready, busy;
  logic [1:0]   res_id;
  logic [15:0]  done_cnt;

  logic [3:0]   req_valid3, req_ready3;
  logic [127:0] req_int3;
  logic [31:0]  conv_int3, conv_fp3, res_fp3;
  logic         res_valid3, res_ready3, busy3;
  logic [1:0]   res_id3;
  logic [15:0]  done_cnt3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_done;

  always #5 clk = ~clk;

  // Signed int32 to IEEE-754 single, round to nearest even.
  function automatic logic [31:0] i2f(input logic [31:0] v);
    logic        s;
    logic [31:0] m, sh;
    logic [4:0]  p;
    logic [23:0] man;
    logic        rnd;
    logic [24:0] r;
    logic [7:0]  e;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    m = s ? (~v + 32'd1) : v;
    p = 5'd31;
    while (m[p] == 1'b0) p = p - 5'd1;
    sh  = m << (5'd31 - p);
    man = sh[31:8];
    rnd = sh[7] & ((|sh[6:0]) | man[0]);
    r   = {1'b0, man} + {24'd0, rnd};
    e   = 8'd127 + {3'd0, p};
    if (r[24]) begin
      r = r >> 1;
      e = e + 8'd1;
    end
    return {s, e, r[22:0]};
  endfunction

  assign conv_fp  = i2f(conv_int);
  assign conv_fp3 = i2f(conv_int3);

  int_to_fp_arbiter #(.NUM_REQ(4), .ID_W(2), .CONV_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_int(req_int), .req_ready(req_ready),
    .conv_int(conv_int), .conv_fp(conv_fp),
    .res_valid(res_valid), .res_ready(res_ready), .res_fp(res_fp), .res_id(res_id),
    .busy(busy), .done_cnt(done_cnt)
  );

  int_to_fp_arbiter #(.NUM_REQ(4), .ID_W(2), .CONV_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_int(req_int3), .req_ready(req_ready3),
    .conv_int(conv_int3), .conv_fp(conv_fp3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_fp(res_fp3), .res_id(res_id3),
    .busy(busy3), .done_cnt(done_cnt3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0; req_int = '0; res_ready = 1'b1;
    req_valid3 = '0; req_int3 = '0; res_ready3 = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_cmp++; if (done_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_done_cnt: got %h want 0000", done_cnt); end
    n_cmp++; if (conv_int !== 32'h0) begin n_bad++; $display("FAIL reset_conv_int: got %h want 00000000", conv_int); end
    n_cmp++; if (res_fp !== 32'h0 || res_id !== 2'd0) begin n_bad++; $display("FAIL reset_res: got %h/%0d want 00000000/0", res_fp, res_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single;
    req_valid = 4'b0001;
    req_int   = {96'd0, 32'h000005B0};
    res_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick;
    req_valid = 4'b0000;
    #1;
    n_cmp++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_wait: got busy=%b ready=%b want 1/0000", busy, req_ready); end
    n_cmp++; if (conv_int !== 32'h000005B0) begin n_bad++; $display("FAIL single_conv_int: got %h want 000005B0", conv_int); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
    tick;
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", res_valid); end
    n_cmp++; if (res_fp !== 32'h44B60000) begin n_bad++; $display("FAIL single_fp: got %h want 44B60000", res_fp); end
    n_cmp++; if (res_id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d want 0", res_id); end
    tick;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_done_state: got valid=%b busy=%b want 0/0", res_valid, busy); end
    n_cmp++; if (done_cnt !== 16'd1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_round_robin;
    logic [1:0]  g;
    logic [31:0] ef;
    logic [3:0]  er;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_done = 16'd0;
    req_valid = 4'b1111;
    req_int   = {32'd4, 32'd3, 32'd2, 32'd1};
    res_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      g  = 2'(i);
      er = 4'b0001 << g;
      case (g)
        2'd0:    ef = 32'h3F800000;
        2'd1:    ef = 32'h40000000;
        2'd2:    ef = 32'h40400000;
        default: ef = 32'h40800000;
      endcase
      n_cmp++; if (req_ready !== er) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", i, req_ready, er); end
      tick;
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_wait_ready_%0d: got %b want 0000", i, req_ready); end
      tick;
      n_cmp++; if (res_valid !== 1'b1 || res_fp !== ef || res_id !== g) begin
        n_bad++; $display("FAIL rr_result_%0d: got v=%b fp=%h id=%0d want 1/%h/%0d", i, res_valid, res_fp, res_id, ef, g);
      end
      tick;
      exp_done = exp_done + 16'd1;
    end
    req_valid = 4'b0000;
    #1;
    n_cmp++; if (done_cnt !== exp_done) begin n_bad++; $display("FAIL rr_done_cnt: got %0d want %0d", done_cnt, exp_done); end
  endtask

  task automatic test_backpressure;
    req_valid = 4'b0100;
    req_int   = {32'd0, 32'd7, 32'd0, 32'd0};
    res_ready = 1'b0;
    tick;
    req_valid = 4'b1111;
    tick;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (res_valid !== 1'b1 || res_fp !== 32'h40E00000 || res_id !== 2'd2) begin
        n_bad++; $display("FAIL bp_hold_%0d: got v=%b fp=%h id=%0d want 1/40E00000/2", i, res_valid, res_fp, res_id);
      end
      n_cmp++; if (req_ready !== 4'b0000 || conv_int !== 32'd7) begin
        n_bad++; $display("FAIL bp_no_accept_%0d: got ready=%b conv=%h want 0000/00000007", i, req_ready, conv_int);
      end
      n_cmp++; if (done_cnt !== exp_done) begin n_bad++; $display("FAIL bp_done_hold_%0d: got %0d want %0d", i, done_cnt, exp_done); end
      tick;
    end
    res_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_complete_ready: got %b want 0000", req_ready); end
    tick;
    exp_done = exp_done + 16'd1;
    n_cmp++; if (res_valid !== 1'b0 || done_cnt !== exp_done) begin
      n_bad++; $display("FAIL bp_complete: got v=%b done=%0d want 0/%0d", res_valid, done_cnt, exp_done);
    end
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_latency3;
    req_valid3 = 4'b0001;
    req_int3   = '0;
    res_ready3 = 1'b1;
    #1;
    n_cmp++; if (req_ready3 !== 4'b0001) begin n_bad++; $display("FAIL lat3_ready: got %b want 0001", req_ready3); end
    tick;
    req_valid3 = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      n_cmp++; if (res_valid3 !== 1'b0 || busy3 !== 1'b1) begin
        n_bad++; $display("FAIL lat3_wait_%0d: got v=%b busy=%b want 0/1", k, res_valid3, busy3);
      end
      tick;
    end
    n_cmp++; if (res_valid3 !== 1'b1 || res_fp3 !== 32'h0 || res_id3 !== 2'd0) begin
      n_bad++; $display("FAIL lat3_result: got v=%b fp=%h id=%0d want 1/00000000/0", res_valid3, res_fp3, res_id3);
    end
    tick;
    n_cmp++; if (done_cnt3 !== 16'd1 || res_valid3 !== 1'b0) begin
      n_bad++; $display("FAIL lat3_done: got done=%0d v=%b want 1/0", done_cnt3, res_valid3);
    end
  endtask

  task automatic test_reset_in_wait;
    req_valid = 4'b0010;
    req_int   = {32'd0, 32'd0, 32'h99, 32'd0};
    res_ready = 1'b1;
    tick;
    req_valid = 4'b0000;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rw_in_wait: got busy=%b want 1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_bad++; $display("FAIL rw_state: got busy=%b v=%b want 0/0", busy, res_valid); end
    n_cmp++; if (done_cnt !== 16'd0 || conv_int !== 32'd0) begin
      n_bad++; $display("FAIL rw_regs: got done=%0d conv=%h want 0/00000000", done_cnt, conv_int);
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rw_rr_ptr: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rw_dropped_%0d: got v=%b busy=%b want 0/0", i, res_valid, busy);
      end
    end
  endtask

  task automatic test_wrap;
    force dut.done_q = 16'hFFFF;
    #1;
    release dut.done_q;
    #1;
    n_cmp++; if (done_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want FFFF", done_cnt); end
    req_valid = 4'b0001;
    req_int   = {96'd0, 32'd2};
    res_ready = 1'b1;
    tick;
    req_valid = 4'b0000;
    tick;
    n_cmp++; if (res_valid !== 1'b1 || res_fp !== 32'h40000000) begin
      n_bad++; $display("FAIL wrap_result: got v=%b fp=%h want 1/40000000", res_valid, res_fp);
    end
    tick;
    n_cmp++; if (done_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_done_cnt: got %h want 0000", done_cnt); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_latency3;
    test_reset_in_wait;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
